// File: rtl/fifo_basic_pkg.sv
// Shared defaults for the fifo_basic storage geometry.
package fifo_basic_pkg;

  localparam int unsigned DefaultDataW = 8;
  localparam int unsigned DefaultDepth = 8;

endpackage

// File: rtl/fifo_basic_mem.sv
// DEPTH x DATA_W storage: synchronous write port, registered read port.
module fifo_basic_mem #(
  parameter  int unsigned DataW = 8,
  parameter  int unsigned Depth = 8,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  // Array is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_basic.sv
// Synchronous FIFO: pointers, occupancy count and flags around a registered-read memory.
module fifo_basic
  import fifo_basic_pkg::*;
#(
  parameter  int unsigned DATA_W = DefaultDataW,
  parameter  int unsigned DEPTH  = DefaultDepth,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic              r_en,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_basic: DEPTH must be a power of two and at least 2");
  end

  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wr_acc, rd_acc;

  assign full   = (count_q == DepthCnt);
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + (ADDR_W + 1)'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - (ADDR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_basic_mem #(
    .DataW (DATA_W),
    .Depth (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_acc & rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (out_data)
  );

endmodule

// File: tb/tb_fifo_basic.sv
// Directed self-checking bench for fifo_basic (DATA_W = 8, DEPTH = 8).
module tb_fifo_basic;

  logic       clk;
  logic       rst;
  logic       w_en;
  logic       r_en;
  logic [7:0] in_data;
  logic [7:0] out_data;
  logic       full;
  logic       empty;
  logic [3:0] count;

  int n_cmp;
  int n_err;

  fifo_basic #(
    .DATA_W (8),
    .DEPTH  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .w_en     (w_en),
    .r_en     (r_en),
    .in_data  (in_data),
    .out_data (out_data),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0; in_data = 8'h00;
    tick();
    tick();
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full got %b want 0", full); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_out got %h want 00", out_data); end
    rst = 1'b1;
  endtask

  task automatic test_write_four();
    logic [7:0] d [4];
    d = '{8'h24, 8'h81, 8'h09, 8'h63};
    for (int i = 0; i < 4; i++) begin
      w_en = 1'b1; in_data = d[i];
      tick();
    end
    w_en = 1'b0;
    n_cmp++; if (count !== 4'd4) begin n_err++; $display("FAIL wr4_count got %0d want 4", count); end
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL wr4_empty got %b want 0", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL wr4_full got %b want 0", full); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL wr4_out got %h want 00", out_data); end
  endtask

  task automatic test_read_four();
    logic [7:0] e [4];
    e = '{8'h24, 8'h81, 8'h09, 8'h63};
    r_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (out_data !== e[i]) begin
        n_err++; $display("FAIL rd4_out[%0d] got %h want %h", i, out_data, e[i]);
      end
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rd4_empty got %b want 1", empty); end
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL rd4_count got %0d want 0", count); end
  endtask

  task automatic test_read_empty();
    r_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_data !== 8'h63) begin n_err++; $display("FAIL rdempty_out got %h want 63", out_data); end
      n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL rdempty_count got %0d want 0", count); end
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rdempty_empty got %b want 1", empty); end
    end
    r_en = 1'b0;
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 8; i++) begin
      w_en = 1'b1; in_data = 8'(i);
      tick();
    end
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full got %b want 1", full); end
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL fill_count got %0d want 8", count); end
    in_data = 8'hFF;
    tick();
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL drop_count got %0d want 8", count); end
    n_cmp++; if (out_data !== 8'h63) begin n_err++; $display("FAIL drop_out got %h want 63", out_data); end
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL drop_empty got %b want 0", empty); end
    // Full with both requests: only the read goes through.
    in_data = 8'hAA; r_en = 1'b1;
    tick();
    n_cmp++; if (count !== 4'd7) begin n_err++; $display("FAIL fullboth_count got %0d want 7", count); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL fullboth_out got %h want 00", out_data); end
    w_en = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      n_cmp++;
      if (out_data !== 8'(i)) begin
        n_err++; $display("FAIL drain_out[%0d] got %h want %h", i, out_data, 8'(i));
      end
    end
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL drain_count got %0d want 0", count); end
    // Empty with both requests: only the write goes through.
    w_en = 1'b1; in_data = 8'h5C;
    tick();
    n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL emptyboth_count got %0d want 1", count); end
    n_cmp++; if (out_data !== 8'h07) begin n_err++; $display("FAIL emptyboth_out got %h want 07", out_data); end
    w_en = 1'b0;
    tick();
    n_cmp++; if (out_data !== 8'h5C) begin n_err++; $display("FAIL emptyboth_rd got %h want 5c", out_data); end
    r_en = 1'b0;
  endtask

  task automatic test_wraparound();
    logic [7:0] e [10];
    e = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    // Pointers sit at 5 here, so these writes wrap the write pointer.
    for (int i = 0; i < 4; i++) begin
      w_en = 1'b1; in_data = 8'h10 + 8'(i);
      tick();
    end
    n_cmp++; if (count !== 4'd4) begin n_err++; $display("FAIL wrap_pre_count got %0d want 4", count); end
    r_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'h20 + 8'(i);
      tick();
      n_cmp++;
      if (out_data !== e[i]) begin
        n_err++; $display("FAIL wrap_out[%0d] got %h want %h", i, out_data, e[i]);
      end
      n_cmp++;
      if (count !== 4'd4) begin
        n_err++; $display("FAIL wrap_count[%0d] got %0d want 4", i, count);
      end
    end
    w_en = 1'b0; r_en = 1'b0;
  endtask

  task automatic test_reset_midstream();
    w_en = 1'b1; in_data = 8'h77;
    tick();
    n_cmp++; if (count !== 4'd5) begin n_err++; $display("FAIL mid_pre_count got %0d want 5", count); end
    // Reset wins over simultaneous requests.
    rst = 1'b0; r_en = 1'b1;
    tick();
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL mid_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL mid_empty got %b want 1", empty); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL mid_out got %h want 00", out_data); end
    rst = 1'b1; r_en = 1'b0; in_data = 8'hC3;
    tick();
    n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL post_wr_count got %0d want 1", count); end
    w_en = 1'b0; r_en = 1'b1;
    tick();
    n_cmp++; if (out_data !== 8'hC3) begin n_err++; $display("FAIL post_rd_out got %h want c3", out_data); end
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL post_rd_count got %0d want 0", count); end
    r_en = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_write_four();
    test_read_four();
    test_read_empty();
    test_fill_overflow();
    test_wraparound();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
